prog_timer: RTL and testbench



---
 rtl/prog_timer.sv | 178 +++++++++++++++++
 tb/tb_prog_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// -----------------------------------------------------------------------------
// prog_timer
//
// Programmable down-counter timer with a clock prescaler, one-shot and periodic
// modes, pause/resume, abort, and optional retrigger. It is meant as a reusable
// delay/interval source beside control FSMs.
//
// Parameters:
//   WIDTH      - width of LOAD_VAL and COUNT
//   PRESCALE_W - width of the prescaler reload value
//   RETRIGGER  - 1: START while active restarts the timer; 0: START is ignored
//
// Ports:
//   CLK      in   clock, all state updates on the rising edge
//   RESET    in   asynchronous, active-high reset
//   START    in   start request (sampled on CLK)
//   STOP     in   abort request (sampled on CLK), highest priority
//   PAUSE    in   level, freezes counting while high
//   MODE     in   0 = one-shot, 1 = periodic (latched at start)
//   LOAD_VAL in   terminal count L (latched at start)
//   PRESCALE in   prescaler P, COUNT decrements every P+1 active edges
//   READY    out  high while IDLE
//   BUSY     out  high while COUNTING or PAUSED
//   DONE     out  registered one-cycle pulse at terminal count
//   COUNT    out  current remaining count
// -----------------------------------------------------------------------------
module prog_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8,
  parameter int RETRIGGER  = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  PAUSE,
  input  logic                  MODE,
  input  logic [WIDTH-1:0]      LOAD_VAL,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [WIDTH-1:0]      COUNT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PAUSED   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                state, next_state;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [WIDTH-1:0]      l_q, l_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  mode_q, mode_d;
  logic                  done_q, done_d;
  logic                  do_load;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers: remaining count, prescale counter, latched settings
  // and the registered DONE pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      p_q     <= '0;
      l_q     <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      p_q     <= p_d;
      l_q     <= l_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-datapath logic. Priority is STOP > START > PAUSE >
  // normal counting. A (re)start is folded into do_load so IDLE and retrigger
  // share exactly the same load behaviour, including the zero-length case,
  // which completes immediately without ever leaving IDLE.
  always_comb begin
    next_state = state;
    count_d    = count_q;
    p_d        = p_q;
    l_d        = l_q;
    pre_d      = pre_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    do_load    = 1'b0;

    case (state)
      IDLE: begin
        if (START && !STOP) begin
          do_load = 1'b1;
        end
      end
      COUNTING, PAUSED: begin
        if (STOP) begin
          next_state = IDLE;
          count_d    = '0;
          p_d        = '0;
        end else if (START && (RETRIGGER != 0)) begin
          do_load = 1'b1;
        end else if (PAUSE) begin
          next_state = PAUSED;
        end else begin
          next_state = COUNTING;
          if (p_q != '0) begin
            p_d = p_q - PRE_ONE;
          end else begin
            // Prescaler tick: reload p and step the count down, never wrapping.
            p_d = pre_q;
            if (count_q != '0) begin
              count_d = count_q - CNT_ONE;
              if (count_q == CNT_ONE) begin
                done_d = 1'b1;
                if (mode_q) begin
                  count_d = l_q;
                end else begin
                  count_d    = '0;
                  p_d        = '0;
                  next_state = IDLE;
                end
              end
            end
          end
        end
      end
      default: begin
        next_state = IDLE;
        count_d    = '0;
        p_d        = '0;
      end
    endcase

    if (do_load) begin
      if (LOAD_VAL != '0) begin
        l_d        = LOAD_VAL;
        pre_d      = PRESCALE;
        mode_d     = MODE;
        count_d    = LOAD_VAL;
        p_d        = PRESCALE;
        next_state = COUNTING;
      end else begin
        count_d    = '0;
        p_d        = '0;
        done_d     = 1'b1;
        next_state = IDLE;
      end
    end
  end

  // Status outputs decode straight from state so they react to reset at once.
  always_comb begin
    READY = (state == IDLE);
    BUSY  = (state == COUNTING) || (state == PAUSED);
  end

  assign DONE  = done_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// -----------------------------------------------------------------------------
// tb_prog_timer
//
// Directed bench for prog_timer. Two instances share all inputs: dut_r has
// retrigger enabled, dut_n has it disabled. Expected outputs are pushed to a
// scoreboard queue as each step is driven and popped/compared after the edge.
// -----------------------------------------------------------------------------
module tb_prog_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  typedef struct {
    bit          sel;
    string       tag;
    logic        ready;
    logic        busy;
    logic        done;
    logic [W-1:0] count;
  } exp_t;

  logic          CLK;
  logic          RESET;
  logic          START;
  logic          STOP;
  logic          PAUSE;
  logic          MODE;
  logic [W-1:0]  LOAD_VAL;
  logic [PW-1:0] PRESCALE;

  logic          ready_r, busy_r, done_r;
  logic [W-1:0]  count_r;
  logic          ready_n, busy_n, done_n;
  logic [W-1:0]  count_n;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  prog_timer #(.WIDTH(W), .PRESCALE_W(PW), .RETRIGGER(1)) dut_r (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .MODE(MODE), .LOAD_VAL(LOAD_VAL), .PRESCALE(PRESCALE),
    .READY(ready_r), .BUSY(busy_r), .DONE(done_r), .COUNT(count_r)
  );

  prog_timer #(.WIDTH(W), .PRESCALE_W(PW), .RETRIGGER(0)) dut_n (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .MODE(MODE), .LOAD_VAL(LOAD_VAL), .PRESCALE(PRESCALE),
    .READY(ready_n), .BUSY(busy_n), .DONE(done_n), .COUNT(count_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic start, input logic stop,
                               input logic pause, input logic mode,
                               input logic [W-1:0] load,
                               input logic [PW-1:0] pre);
    START    = start;
    STOP     = stop;
    PAUSE    = pause;
    MODE     = mode;
    LOAD_VAL = load;
    PRESCALE = pre;
  endtask

  task automatic pushExp(input bit sel, input string tag, input logic r,
                         input logic b, input logic d, input logic [W-1:0] c);
    exp_t e;
    e.sel   = sel;
    e.tag   = tag;
    e.ready = r;
    e.busy  = b;
    e.done  = d;
    e.count = c;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drain the scoreboard against the current DUT outputs.
  task automatic checkOutput();
    exp_t         e;
    logic         r, b, d;
    logic [W-1:0] c;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        r = ready_n; b = busy_n; d = done_n; c = count_n;
      end else begin
        r = ready_r; b = busy_r; d = done_r; c = count_r;
      end
      cmp({e.tag, ".ready"}, {{(W-1){1'b0}}, r}, {{(W-1){1'b0}}, e.ready});
      cmp({e.tag, ".busy"},  {{(W-1){1'b0}}, b}, {{(W-1){1'b0}}, e.busy});
      cmp({e.tag, ".done"},  {{(W-1){1'b0}}, d}, {{(W-1){1'b0}}, e.done});
      cmp({e.tag, ".count"}, c, e.count);
    end
  endtask

  task automatic edgeStep();
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [W-1:0] cnt2 [15];
    logic [W-1:0] cnt3 [7];
    logic [W-1:0] cr [9];
    logic [W-1:0] cn [9];

    cnt2 = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd3, 16'd3,
             16'd2, 16'd2, 16'd1, 16'd1, 16'd3, 16'd3, 16'd2};
    cnt3 = '{16'd4, 16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
    cr   = '{16'd5, 16'd4, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    cn   = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};

    // Reset state.
    RESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'd0, 8'd0);
    #2;
    pushExp(0, "reset_r", 1, 0, 0, 16'd0);
    pushExp(1, "reset_n", 1, 0, 0, 16'd0);
    checkOutput();
    #6;
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // One-shot L=3 P=0.
    applyStimulus(1, 0, 0, 0, 16'd3, 8'd0);
    pushExp(0, "os_e0", 0, 1, 0, 16'd3);
    edgeStep();
    applyStimulus(0, 0, 0, 0, 16'd3, 8'd0);
    pushExp(0, "os_e1", 0, 1, 0, 16'd2);
    edgeStep();
    pushExp(0, "os_e2", 0, 1, 0, 16'd1);
    edgeStep();
    pushExp(0, "os_done", 1, 0, 1, 16'd0);
    pushExp(1, "os_done_n", 1, 0, 1, 16'd0);
    edgeStep();
    pushExp(0, "os_after", 1, 0, 0, 16'd0);
    edgeStep();

    // Periodic L=3 P=1; inputs change after start and must be ignored.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(k == 0, 0, 0, (k == 0), (k == 0) ? 16'd3 : 16'd9,
                    (k == 0) ? 8'd1 : 8'd5);
      pushExp(0, $sformatf("per_e%0d", k), 0, 1, (k == 6 || k == 12), cnt2[k]);
      edgeStep();
    end
    applyStimulus(0, 1, 0, 1, 16'd3, 8'd1);
    pushExp(0, "per_stop", 1, 0, 0, 16'd0);
    edgeStep();
    applyStimulus(0, 0, 0, 1, 16'd3, 8'd1);
    for (int k = 16; k < 21; k++) begin
      pushExp(0, $sformatf("per_idle_e%0d", k), 1, 0, 0, 16'd0);
      edgeStep();
    end

    // Pause for two edges mid-count, L=4 P=0.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(k == 0, 0, (k == 2 || k == 3), 0, 16'd4, 8'd0);
      pushExp(0, $sformatf("pause_e%0d", k), (k == 6), (k != 6), (k == 6),
              cnt3[k]);
      edgeStep();
    end

    // Retrigger at E3 with LOAD_VAL=4: dut_r restarts, dut_n ignores it.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(k == 0 || k == 3, 0, 0, 0, (k == 3) ? 16'd4 : 16'd5, 8'd0);
      pushExp(0, $sformatf("rt_r_e%0d", k), (k >= 7), (k <= 6), (k == 7), cr[k]);
      pushExp(1, $sformatf("rt_n_e%0d", k), (k >= 5), (k <= 4), (k == 5), cn[k]);
      edgeStep();
    end

    // Zero-length start in periodic mode: single DONE, never leaves IDLE.
    applyStimulus(1, 0, 0, 1, 16'd0, 8'd2);
    pushExp(0, "zero_e0", 1, 0, 1, 16'd0);
    pushExp(1, "zero_e0_n", 1, 0, 1, 16'd0);
    edgeStep();
    applyStimulus(0, 0, 0, 1, 16'd0, 8'd2);
    pushExp(0, "zero_e1", 1, 0, 0, 16'd0);
    edgeStep();
    pushExp(0, "zero_e2", 1, 0, 0, 16'd0);
    edgeStep();

    // START with STOP in IDLE does not start.
    applyStimulus(1, 1, 0, 0, 16'd3, 8'd0);
    pushExp(0, "startstop", 1, 0, 0, 16'd0);
    edgeStep();

    // Retrigger with LOAD_VAL=0 while active: dut_r completes at once.
    applyStimulus(1, 0, 0, 0, 16'd6, 8'd0);
    pushExp(0, "rz_e0", 0, 1, 0, 16'd6);
    edgeStep();
    applyStimulus(1, 0, 0, 0, 16'd0, 8'd0);
    pushExp(0, "rz_e1_r", 1, 0, 1, 16'd0);
    pushExp(1, "rz_e1_n", 0, 1, 0, 16'd5);
    edgeStep();
    applyStimulus(0, 1, 0, 0, 16'd0, 8'd0);
    pushExp(1, "rz_stop_n", 1, 0, 0, 16'd0);
    edgeStep();

    // Asynchronous reset mid-count.
    applyStimulus(1, 0, 0, 0, 16'd10, 8'd0);
    pushExp(0, "ar_e0", 0, 1, 0, 16'd10);
    edgeStep();
    applyStimulus(0, 0, 0, 0, 16'd10, 8'd0);
    pushExp(0, "ar_e1", 0, 1, 0, 16'd9);
    edgeStep();
    #2;
    RESET = 1'b1;
    #1;
    pushExp(0, "ar_now_r", 1, 0, 0, 16'd0);
    pushExp(1, "ar_now_n", 1, 0, 0, 16'd0);
    checkOutput();
    #3;
    RESET = 1'b0;
    for (int k = 0; k < 12; k++) begin
      pushExp(0, $sformatf("ar_idle%0d", k), 1, 0, 0, 16'd0);
      edgeStep();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
